// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and helpers for the register hazard scoreboard.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF   = 3;
    localparam int unsigned MAX_LAT_DEF  = 2;
    localparam int unsigned FWD_DIST_DEF = 0;
    localparam int unsigned STALL_CW_DEF = 16;
    localparam int unsigned LAT_W        = 4;

    function automatic int unsigned pend_width(input int unsigned max_lat);
        return $clog2(max_lat + 1);
    endfunction

    // Zero latency is treated as a single-cycle op; oversized latencies clamp to the tracked maximum.
    function automatic logic [LAT_W-1:0] lat_eff(input logic [LAT_W-1:0] lat,
                                                 input int unsigned       max_lat);
        if (lat == '0)
            return LAT_W'(1);
        else if (32'(lat) > max_lat)
            return LAT_W'(max_lat);
        else
            return lat;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request / scoreboard verdict bundle.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_rs1_used_i;
    logic              id_rs2_used_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_reg_write_i;
    logic [LAT_W-1:0]  id_lat_i;
    logic              hazard_o;
    logic              issue_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_i, id_reg_write_i, id_lat_i,
        input  hazard_o, issue_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_i, id_reg_write_i, id_lat_i,
        output hazard_o, issue_o
    );
endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One register's pending-writeback countdown.
module hazard_sb_entry #(
    parameter int unsigned PW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [PW-1:0] load_val,
    output logic [PW-1:0] pend,
    output logic          busy
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pend <= '0;
        else if (load)
            pend <= load_val;
        else if (pend != '0)
            pend <= pend - 1'b1;
    end

    assign busy = |pend;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register RAW/WAW scoreboard deciding stall vs issue for the ID stage.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned  REG_AW   = REG_AW_DEF,
    parameter int unsigned  MAX_LAT  = MAX_LAT_DEF,
    parameter int unsigned  FWD_DIST = FWD_DIST_DEF,
    parameter int unsigned  STALL_CW = STALL_CW_DEF,
    localparam int unsigned NUM_REGS = 2**REG_AW
) (
    input  logic                clk,
    input  logic                rst,
    hazard_scoreboard_if.slave  id,
    input  logic                stat_clr_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [STALL_CW-1:0] stall_cnt_o
);

    localparam int unsigned      PW    = pend_width(MAX_LAT);
    localparam logic [LAT_W-1:0] FWD_V = LAT_W'(FWD_DIST);

    logic [PW-1:0]    pend [NUM_REGS];
    logic [LAT_W-1:0] lat_e;
    logic             raw1;
    logic             raw2;
    logic             waw;
    logic             hazard;
    logic             issue;

    assign lat_e   = lat_eff(id.id_lat_i, MAX_LAT);
    assign pend[0] = '0;
    assign busy_o[0] = 1'b0;

    // Hazards look at the pre-load count, so an instruction never stalls on its own rd.
    always_comb begin
        raw1   = id.id_rs1_used_i && (id.id_rs1_i != '0)
                 && (LAT_W'(pend[id.id_rs1_i]) > FWD_V);
        raw2   = id.id_rs2_used_i && (id.id_rs2_i != '0)
                 && (LAT_W'(pend[id.id_rs2_i]) > FWD_V);
        waw    = id.id_reg_write_i && (id.id_rd_i != '0)
                 && (LAT_W'(pend[id.id_rd_i]) > lat_e);
        hazard = id.id_valid_i && (raw1 || raw2 || waw);
        issue  = id.id_valid_i && !hazard;
    end

    assign id.hazard_o = hazard;
    assign id.issue_o  = issue;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic ld;
        assign ld = issue && id.id_reg_write_i && (id.id_rd_i == REG_AW'(r));

        hazard_sb_entry #(.PW(PW)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (ld),
            .load_val (PW'(lat_e)),
            .pend     (pend[r]),
            .busy     (busy_o[r])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_o <= '0;
        else if (stat_clr_i)
            stall_cnt_o <= '0;
        else if (hazard && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and legacy-reference checks for hazard_scoreboard in three configurations.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       v, u1, u2, wr, clr;
    logic [2:0] rs1, rs2, rd;
    logic [3:0] lat;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_AW(3)) ifa ();
    hazard_scoreboard_if #(.REG_AW(3)) ifb ();
    hazard_scoreboard_if #(.REG_AW(3)) ifc ();

    assign ifa.id_valid_i = v;   assign ifb.id_valid_i = v;   assign ifc.id_valid_i = v;
    assign ifa.id_rs1_i = rs1;   assign ifb.id_rs1_i = rs1;   assign ifc.id_rs1_i = rs1;
    assign ifa.id_rs2_i = rs2;   assign ifb.id_rs2_i = rs2;   assign ifc.id_rs2_i = rs2;
    assign ifa.id_rs1_used_i = u1; assign ifb.id_rs1_used_i = u1; assign ifc.id_rs1_used_i = u1;
    assign ifa.id_rs2_used_i = u2; assign ifb.id_rs2_used_i = u2; assign ifc.id_rs2_used_i = u2;
    assign ifa.id_rd_i = rd;     assign ifb.id_rd_i = rd;     assign ifc.id_rd_i = rd;
    assign ifa.id_reg_write_i = wr; assign ifb.id_reg_write_i = wr; assign ifc.id_reg_write_i = wr;
    assign ifa.id_lat_i = lat;   assign ifb.id_lat_i = lat;   assign ifc.id_lat_i = lat;

    logic [7:0]  busy_a, busy_b, busy_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    hazard_scoreboard #(.REG_AW(3), .MAX_LAT(2), .FWD_DIST(0), .STALL_CW(16)) dut_a (
        .clk(clk), .rst(rst), .id(ifa), .stat_clr_i(clr), .busy_o(busy_a), .stall_cnt_o(cnt_a));
    hazard_scoreboard #(.REG_AW(3), .MAX_LAT(3), .FWD_DIST(1), .STALL_CW(16)) dut_b (
        .clk(clk), .rst(rst), .id(ifb), .stat_clr_i(clr), .busy_o(busy_b), .stall_cnt_o(cnt_b));
    hazard_scoreboard #(.REG_AW(3), .MAX_LAT(2), .FWD_DIST(0), .STALL_CW(2)) dut_c (
        .clk(clk), .rst(rst), .id(ifc), .stat_clr_i(clr), .busy_o(busy_c), .stall_cnt_o(cnt_c));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       v;
        logic [2:0] rs1;
        logic       u1;
        logic [2:0] rs2;
        logic       u2;
        logic [2:0] rd;
        logic       wr;
        logic [3:0] lat;
        logic       clr;
        logic       hz;
        logic       is;
        logic [7:0] busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [2:0] irs1, input logic iu1,
                         input logic [2:0] irs2, input logic iu2, input logic [2:0] ird,
                         input logic iwr, input logic [3:0] ilat, input logic iclr);
        @(negedge clk);
        v = iv; rs1 = irs1; u1 = iu1; rs2 = irs2; u2 = iu2;
        rd = ird; wr = iwr; lat = ilat; clr = iclr;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        v = 1'b0; rs1 = '0; u1 = 1'b0; rs2 = '0; u2 = 1'b0;
        rd = '0; wr = 1'b0; lat = '0; clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] ex_rd, mem_rd;
        logic       ex_w, mem_w, exp_hz;
        logic       exp_hz_c [8];
        logic [1:0] exp_cnt_c [8];

        // {v,rs1,u1,rs2,u2,rd,wr,lat,clr, hazard,issue,busy,stall_cnt} for dut_a
        tbl[0]  = '{0,0,0,0,0,0,0,0,0, 0,0,8'h00,0};
        tbl[1]  = '{1,0,0,0,0,3,1,2,0, 0,1,8'h00,0};
        tbl[2]  = '{0,0,0,0,0,0,0,0,0, 0,0,8'h08,0};
        tbl[3]  = '{1,3,1,0,0,0,0,0,0, 1,0,8'h08,0};
        tbl[4]  = '{1,3,1,0,0,0,0,0,0, 0,1,8'h00,1};
        tbl[5]  = '{1,0,0,0,0,4,1,2,0, 0,1,8'h00,1};
        tbl[6]  = '{1,0,1,4,0,0,0,0,0, 0,1,8'h10,1};
        tbl[7]  = '{1,0,0,0,0,1,1,0,0, 0,1,8'h10,1};
        tbl[8]  = '{0,0,0,0,0,0,0,0,0, 0,0,8'h02,1};
        tbl[9]  = '{1,0,0,0,0,2,1,9,0, 0,1,8'h00,1};
        tbl[10] = '{0,0,0,0,0,0,0,0,0, 0,0,8'h04,1};
        tbl[11] = '{0,0,0,0,0,0,0,0,0, 0,0,8'h04,1};
        tbl[12] = '{1,0,0,0,0,6,1,1,0, 0,1,8'h00,1};
        tbl[13] = '{0,0,0,0,0,0,0,0,0, 0,0,8'h40,1};
        tbl[14] = '{1,6,1,0,0,0,0,0,0, 0,1,8'h00,1};
        tbl[15] = '{1,5,1,0,0,5,1,2,0, 0,1,8'h00,1};
        tbl[16] = '{0,5,1,5,1,5,1,2,0, 0,0,8'h20,1};
        tbl[17] = '{1,0,0,5,1,0,0,0,0, 1,0,8'h20,1};
        tbl[18] = '{0,0,0,0,0,0,0,0,0, 0,0,8'h00,2};
        tbl[19] = '{0,0,0,0,0,0,0,0,1, 0,0,8'h00,2};
        tbl[20] = '{0,0,0,0,0,0,0,0,0, 0,0,8'h00,0};

        exp_hz_c  = '{1,1,0,1,1,0,1,1};
        exp_cnt_c = '{0,1,2,2,3,3,3,0};

        // Reset held with a would-be hazard and a write on the bus
        rst = 1'b1;
        v = 1'b1; rs1 = 3'd3; u1 = 1'b1; rs2 = '0; u2 = 1'b0;
        rd = 3'd3; wr = 1'b1; lat = 4'd2; clr = 1'b0;
        #2;
        chk("rst_hazard_a", 32'(ifa.hazard_o), 0);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_cnt_a", 32'(cnt_a), 0);
        chk("rst_busy_b", 32'(busy_b), 0);
        @(negedge clk); #2;
        chk("rst_busy_after_edge", 32'(busy_a), 0);
        chk("rst_hazard_after_edge", 32'(ifa.hazard_o), 0);
        do_reset();

        for (int unsigned i = 0; i < 21; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2,
                  tbl[i].rd, tbl[i].wr, tbl[i].lat, tbl[i].clr);
            chk($sformatf("vec%0d_hazard", i), 32'(ifa.hazard_o), 32'(tbl[i].hz));
            chk($sformatf("vec%0d_issue", i), 32'(ifa.issue_o), 32'(tbl[i].is));
            chk($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt_a), 32'(tbl[i].cnt));
        end

        // Forwarding distance 1, max latency 3
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 3, 0);
        chk("fwd_w5_issue", 32'(ifb.issue_o), 1);
        idle();
        chk("fwd_busy5", 32'(busy_b), 32'h20);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("fwd_r5_stall", 32'(ifb.hazard_o), 1);
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
        chk("fwd_r5_hazard_clear", 32'(ifb.hazard_o), 0);
        chk("fwd_r5_issue", 32'(ifb.issue_o), 1);

        drive(1, 0, 0, 0, 0, 2, 1, 3, 0);
        idle();
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
        chk("waw_stall", 32'(ifb.hazard_o), 1);
        drive(1, 0, 0, 0, 0, 2, 1, 1, 0);
        chk("waw_issue", 32'(ifb.issue_o), 1);
        idle();
        chk("waw_reload_busy", 32'(busy_b), 32'h04);
        idle();
        chk("waw_drained", 32'(busy_b), 0);

        drive(1, 0, 1, 0, 1, 0, 1, 3, 0);
        chk("r0_write_issue", 32'(ifb.issue_o), 1);
        drive(1, 0, 1, 0, 1, 0, 1, 3, 0);
        chk("r0_read_hazard", 32'(ifb.hazard_o), 0);
        chk("r0_busy", 32'(busy_b), 0);

        // Two-bit stall counter saturation and clear priority
        do_reset();
        drive(1, 0, 0, 0, 0, 3, 1, 2, 0);
        chk("sat_seed_issue", 32'(ifc.issue_o), 1);
        for (int unsigned i = 0; i < 8; i++) begin
            drive(1, 3, 1, 0, 0, 3, 1, 2, (i == 6) ? 1'b1 : 1'b0);
            chk($sformatf("sat%0d_hazard", i), 32'(ifc.hazard_o), 32'(exp_hz_c[i]));
            chk($sformatf("sat%0d_cnt", i), 32'(cnt_c), 32'(exp_cnt_c[i]));
        end
        idle();
        chk("sat_after_clear", 32'(cnt_c), 1);

        // Asynchronous reset with three writes outstanding
        do_reset();
        drive(1, 0, 0, 0, 0, 1, 1, 3, 0);
        drive(1, 0, 0, 0, 0, 2, 1, 3, 0);
        drive(1, 0, 0, 0, 0, 3, 1, 3, 0);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("arst_pre_busy", 32'(busy_b), 32'h0E);
        chk("arst_pre_hazard", 32'(ifb.hazard_o), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_b), 0);
        chk("arst_hazard", 32'(ifb.hazard_o), 0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("arst_no_residual", 32'(ifb.issue_o), 1);

        // Random stream against the legacy EX/MEM comparator
        do_reset();
        ex_rd = '0; ex_w = 1'b0; mem_rd = '0; mem_w = 1'b0;
        for (int unsigned i = 0; i < 200; i++) begin
            logic       rv, rw;
            logic [2:0] a1, a2, ad;
            rv = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            a1 = 3'($urandom_range(0, 3));
            a2 = 3'($urandom_range(0, 3));
            ad = 3'($urandom_range(0, 3));
            drive(rv, a1, 1, a2, 1, ad, rw, 2, 0);
            exp_hz = rv && (((a1 != 0) && ((ex_w && ex_rd == a1) || (mem_w && mem_rd == a1)))
                         || ((a2 != 0) && ((ex_w && ex_rd == a2) || (mem_w && mem_rd == a2))));
            chk($sformatf("legacy%0d", i), 32'(ifa.hazard_o), 32'(exp_hz));
            mem_rd = ex_rd;
            mem_w  = ex_w;
            ex_rd  = ad;
            ex_w   = rv && !exp_hz && rw;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_AW, default 3: register-address width; NUM_REGS = 2**REG_AW.
REQ-002 Parameter MAX_LAT, default 2: maximum issue-to-writeback latency in cycles, range 1..15.
REQ-003 Parameter FWD_DIST, default 0: remaining-latency count at or below which a result counts as forwardable; range 0..MAX_LAT-1.
REQ-004 Parameter STALL_CW, default 16: width of the stall performance counter.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 id_valid_i  in  1  the ID stage holds a valid instruction.
REQ-009 id_rs1_i, id_rs2_i  in  REG_AW each  source register addresses.
REQ-010 id_rs1_used_i, id_rs2_used_i  in  1 each  the source field is a real operand, not immediate bits.
REQ-011 id_rd_i  in  REG_AW  destination address.
REQ-012 id_reg_write_i  in  1  the instruction writes rd.
REQ-013 id_lat_i  in  4  issue-to-writeback latency of this instruction.
REQ-014 stat_clr_i  in  1  synchronous clear of the stall counter.
REQ-015 hazard_o  out  1  stall the ID stage this cycle.
REQ-016 issue_o  out  1  the instruction issues this cycle.
REQ-017 busy_o  out  NUM_REGS  bit r high when the pending count of register r is nonzero.
REQ-018 stall_cnt_o  out  STALL_CW  saturating count of stall cycles.

Function
REQ-019 The block SHALL hold one pending count pend[r] (width clog2(MAX_LAT+1)) per register r = 1..NUM_REGS-1; register 0 is never tracked, pend[0] is always 0, and busy_o[0] is always 0.
REQ-020 Effective latency SHALL be lat_eff = 1 when id_lat_i = 0, MAX_LAT when id_lat_i > MAX_LAT, and id_lat_i otherwise.
REQ-021 The RAW condition for a source SHALL be: used bit high, address nonzero, and pend[address] > FWD_DIST.
REQ-022 The WAW condition SHALL be: id_reg_write_i high, id_rd_i nonzero, and pend[id_rd_i] > lat_eff.
REQ-023 hazard_o SHALL be combinational from the current state and inputs: id_valid_i AND (RAW on rs1 OR RAW on rs2 OR WAW); it SHALL be 0 when id_valid_i is 0.
REQ-024 issue_o SHALL equal id_valid_i AND NOT hazard_o.
REQ-025 Every cycle, each nonzero pend[r] SHALL decrement by 1.
REQ-026 When issue_o, id_reg_write_i and a nonzero id_rd_i are all high, pend[id_rd_i] SHALL load lat_eff on that edge; the load overrides the decrement of the same entry.
REQ-027 When the issuing instruction reads and writes the same register, RAW is evaluated on the pre-load value, so it SHALL not stall against itself.
REQ-028 A result with lat_eff = 1 SHALL clear busy one cycle after issue; a dependent instruction in the next cycle SHALL see pend = 0 and issue.
REQ-029 stall_cnt_o SHALL increment on every cycle with hazard_o high and SHALL saturate at all-ones.
REQ-030 stat_clr_i SHALL clear stall_cnt_o to 0 and take priority over an increment in the same cycle.
REQ-031 With REG_AW=3, MAX_LAT=2, FWD_DIST=0, lat=2 and both used bits high, hazard_o SHALL be cycle-identical to the legacy EX/MEM two-stage comparator.

Reset
REQ-032 rst SHALL asynchronously clear all pend entries and stall_cnt_o to 0.
REQ-033 While rst is high and after it is released, busy_o SHALL be 0 and hazard_o SHALL be 0 until a write issues.
REQ-034 Assertion of rst mid-operation SHALL discard all pending writes with no residual stall; the pipeline flush is owned by the pipeline control.

Structure
REQ-035 Package hazard_pkg SHALL hold the parameter defaults, the lat_eff clamp function, and the pending-count width function.
REQ-036 One sub-module, hazard_sb_entry (one per-register countdown counter with load/decrement/busy), SHALL be instantiated via generate for registers 1..NUM_REGS-1.
REQ-037 No other sub-modules SHALL be used; the RAW/WAW muxing SHALL stay in the top level.

Verification
REQ-038 Bench: reset, then issue a write to r3 with lat=2, then an instruction reading r3 -> hazard_o=1 for 1 cycle; issue_o=1 on the second cycle; stall_cnt_o=1.
REQ-039 Bench: FWD_DIST=1, MAX_LAT=3; write r5 lat=3, then read r5 -> stall 1 cycle (pend 2 > 1), then issue.
REQ-040 Bench: rs2 = r4 with id_rs2_used_i=0 while r4 is busy -> hazard_o=0; reading r0 while r0 is written with lat=3 -> hazard_o=0, busy_o[0]=0.
REQ-041 Bench: write r2 lat=3, then a write to r2 with lat=1 -> WAW stall for 1 cycle (pend 2 > 1), then issue; pend[r2] = 1.
REQ-042 Bench: id_lat_i=0 gives 1-cycle busy; id_lat_i=9 with MAX_LAT=2 gives 2-cycle busy; stall_cnt_o with STALL_CW=2 saturates at 3; stat_clr_i concurrent with a stall -> 0.
REQ-043 Bench: rst asserted asynchronously with three entries busy -> busy_o=0 and hazard_o=0 immediately; a random-stream comparison against the legacy comparator under the REQ-031 configuration shows zero mismatches.
